// File: rtl/service_2_alarm_ring_pkg.sv
// Shared types and constants for the alarm ring controller slice.
package service_pkg;

  localparam int unsigned BCD_TIME_W = 16;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned SNZ_W      = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  // BCD mm:ss, most significant digit first
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;

endpackage

// File: rtl/service_2_alarm_ring_if.sv
// Alarm ring controller bus: time/button inputs and ring/display outputs.
interface service_2_alarm_ring_if;
  import service_pkg::*;

  bcd_time_t          alarm;
  bcd_time_t          cur_time;
  logic               tick_1hz;
  logic               alarm_en;
  logic               setting;
  logic               push_c;
  logic               push_u;
  logic               ring;
  logic               blink;
  logic [STATE_W-1:0] state;
  logic [SNZ_W-1:0]   snooze_left;

  modport master (
    output alarm, cur_time, tick_1hz, alarm_en, setting, push_c, push_u,
    input  ring, blink, state, snooze_left
  );

  modport slave (
    input  alarm, cur_time, tick_1hz, alarm_en, setting, push_c, push_u,
    output ring, blink, state, snooze_left
  );

endinterface

// File: rtl/service_2_alarm_ring_sec_timer.sv
// 8-bit seconds counter with synchronous clear and a terminal-count flag.
module sec_timer
  import service_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] last,
  output logic             at_last_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_last_c = (cnt == last);

endmodule

// File: rtl/service_2_alarm_ring.sv
// Alarm ring controller: rings on a BCD mm:ss alarm match, dismiss/snooze/auto-stop.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module service_2_alarm_ring
  import service_pkg::*;
#(
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_SEC = 10,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  service_2_alarm_ring_if.slave bus
);

  state_t state_q, state_d;
  logic   ring_q;
  logic   blink_q, blink_d;
  logic   match_c, match_q, hit_c;
  logic   ring_clr_c, ring_inc_c, ring_last_c;

  // Edge of the equality so a held match only fires once
  assign match_c = (bus.cur_time == bus.alarm);
  assign hit_c   = match_c & ~match_q;

  sec_timer u_ring_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (ring_clr_c),
    .inc       (ring_inc_c),
    .last      (CNT_W'(RING_SEC - 1)),
    .at_last_c (ring_last_c)
  );

`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0] snz_left_q, snz_left_d;
  logic             snz_clr_c, snz_inc_c, snz_last_c;

  sec_timer u_snz_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (snz_clr_c),
    .inc       (snz_inc_c),
    .last      (CNT_W'(SNOOZE_SEC - 1)),
    .at_last_c (snz_last_c)
  );

  assign bus.snooze_left = snz_left_q;
`else
  logic unused_snooze_c;
  assign unused_snooze_c = ^{bus.push_u, CNT_W'(SNOOZE_SEC), SNZ_W'(MAX_SNOOZE)};
  assign bus.snooze_left = '0;
`endif

  // Next-state; a button transition takes precedence over a same-cycle tick
  always_comb begin
    state_d    = state_q;
    blink_d    = blink_q;
    ring_clr_c = 1'b0;
    ring_inc_c = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_left_d = snz_left_q;
    snz_clr_c  = 1'b0;
    snz_inc_c  = 1'b0;
`endif
    if (!bus.alarm_en || bus.setting) begin
      state_d = ST_IDLE;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (hit_c) begin
            state_d    = ST_RINGING;
            blink_d    = 1'b0;
            ring_clr_c = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snz_left_d = SNZ_W'(MAX_SNOOZE);
`endif
          end
        end
        ST_RINGING: begin
          if (bus.push_c) begin
            state_d = ST_ARMED;
            blink_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.push_u && (snz_left_q != '0)) begin
            state_d    = ST_SNOOZE;
            blink_d    = 1'b0;
            snz_left_d = snz_left_q - SNZ_W'(1);
            snz_clr_c  = 1'b1;
`endif
          end else if (bus.tick_1hz) begin
            if (ring_last_c) begin
              state_d = ST_ARMED;
              blink_d = 1'b0;
            end else begin
              blink_d    = ~blink_q;
              ring_inc_c = 1'b1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (bus.push_c) begin
            state_d = ST_ARMED;
          end else if (bus.tick_1hz) begin
            if (snz_last_c) begin
              state_d    = ST_RINGING;
              blink_d    = 1'b0;
              ring_clr_c = 1'b1;
            end else begin
              snz_inc_c = 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ring_q     <= 1'b0;
      blink_q    <= 1'b0;
      match_q    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_left_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ring_q     <= (state_d == ST_RINGING);
      blink_q    <= blink_d;
      match_q    <= match_c;
`ifdef ALARM_SNOOZE_EN
      snz_left_q <= snz_left_d;
`endif
    end
  end

  assign bus.state = state_q;
  assign bus.ring  = ring_q;
  assign bus.blink = blink_q;

endmodule

// File: tb/tb_service_2_alarm_ring.sv
// Directed bench for service_2_alarm_ring with a seconds-remaining reference model.
module tb_service_2_alarm_ring;
  import service_pkg::*;

  localparam int RING_SEC   = 30;
  localparam int SNOOZE_SEC = 10;
  localparam int MAX_SNOOZE = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  service_2_alarm_ring_if bus_if ();

  service_2_alarm_ring dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mode 0..3, counting seconds remaining rather than elapsed
  int m_mode, m_ring_left, m_wait, m_snz;
  bit m_blink, m_prev;

  always @(posedge clk or negedge reset_n) begin : model
    bit en, mt, hit;
    if (!reset_n) begin
      m_mode = 0; m_blink = 0; m_snz = 0; m_prev = 0; m_ring_left = 0; m_wait = 0;
    end else begin
      en  = bus_if.alarm_en && !bus_if.setting;
      mt  = (bus_if.cur_time == bus_if.alarm);
      hit = mt && !m_prev;
      m_prev = mt;
      if (!en) begin
        m_mode = 0; m_blink = 0;
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: if (hit) begin
               m_mode = 2; m_blink = 0; m_ring_left = RING_SEC;
               if (SNZ_ON) m_snz = MAX_SNOOZE;
             end
          2: if (bus_if.push_c) begin
               m_mode = 1; m_blink = 0;
             end else if (SNZ_ON && bus_if.push_u && m_snz > 0) begin
               m_mode = 3; m_blink = 0; m_snz = m_snz - 1; m_wait = SNOOZE_SEC;
             end else if (bus_if.tick_1hz) begin
               m_ring_left = m_ring_left - 1;
               if (m_ring_left == 0) begin m_mode = 1; m_blink = 0; end
               else m_blink = !m_blink;
             end
          default: if (bus_if.push_c) begin
               m_mode = 1;
             end else if (bus_if.tick_1hz) begin
               m_wait = m_wait - 1;
               if (m_wait == 0) begin m_mode = 2; m_blink = 0; m_ring_left = RING_SEC; end
             end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_state", 16'(bus_if.state), 16'(m_mode));
      check("model_ring", 16'(bus_if.ring), 16'(m_mode == 2));
      check("model_blink", 16'(bus_if.blink), 16'(m_blink));
      check("model_snooze_left", 16'(bus_if.snooze_left), 16'(m_snz));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.tick_1hz = 1'b1; cyc();
      bus_if.tick_1hz = 1'b0; cyc();
    end
  endtask

  task automatic press(input bit c, input bit u);
    bus_if.push_c = c; bus_if.push_u = u; cyc();
    bus_if.push_c = 1'b0; bus_if.push_u = 1'b0; cyc();
  endtask

  // New occurrence of the alarm time; leaves the controller ringing
  task automatic retrigger();
    bus_if.cur_time = bcd_time_t'(16'h0100); cyc();
    bus_if.cur_time = bcd_time_t'(16'h0105); cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus_if.alarm    = bcd_time_t'(16'h0105);
    bus_if.cur_time = bcd_time_t'(16'h0100);
    bus_if.tick_1hz = 1'b0;
    bus_if.alarm_en = 1'b0;
    bus_if.setting  = 1'b0;
    bus_if.push_c   = 1'b0;
    bus_if.push_u   = 1'b0;
    #1 cmp_en = 1'b1;
    cycles(2);
    check("reset_state", 16'(bus_if.state), 16'd0);
    check("reset_ring", 16'(bus_if.ring), 16'd0);
    check("reset_blink", 16'(bus_if.blink), 16'd0);
    check("reset_snooze_left", 16'(bus_if.snooze_left), 16'd0);
    #2 reset_n = 1'b1;
    cycles(2);
    check("idle_when_disabled", 16'(bus_if.state), 16'd0);

    // Basic ring with blink and auto-stop after RING_SEC ticks
    bus_if.alarm_en = 1'b1; cyc();
    check("armed_after_enable", 16'(bus_if.state), 16'd1);
    bus_if.cur_time = bcd_time_t'(16'h0104); cyc();
    check("no_ring_before_match", 16'(bus_if.ring), 16'd0);
    bus_if.cur_time = bcd_time_t'(16'h0105); cyc();
    check("ring_next_cycle", 16'(bus_if.ring), 16'd1);
    check("ringing_state", 16'(bus_if.state), 16'd2);
    check("blink_zero_on_entry", 16'(bus_if.blink), 16'd0);
    check("snooze_loaded", 16'(bus_if.snooze_left), SNZ_ON ? 16'd3 : 16'd0);
    ticks(1);
    check("blink_after_tick1", 16'(bus_if.blink), 16'd1);
    ticks(1);
    check("blink_after_tick2", 16'(bus_if.blink), 16'd0);
    ticks(27);
    check("still_ringing_29", 16'(bus_if.ring), 16'd1);
    check("blink_after_tick29", 16'(bus_if.blink), 16'd1);
    ticks(1);
    check("auto_stop_ring", 16'(bus_if.ring), 16'd0);
    check("auto_stop_state", 16'(bus_if.state), 16'd1);
    cycles(20);
    check("no_retrigger_held", 16'(bus_if.state), 16'd1);

    // Dismiss beats snooze; dismiss beats tick
    retrigger();
    press(1'b1, 1'b1);
    check("dismiss_priority_state", 16'(bus_if.state), 16'd1);
    check("dismiss_priority_snz", 16'(bus_if.snooze_left), SNZ_ON ? 16'd3 : 16'd0);
    retrigger();
    bus_if.tick_1hz = 1'b1; bus_if.push_c = 1'b1; cyc();
    bus_if.tick_1hz = 1'b0; bus_if.push_c = 1'b0; cyc();
    check("dismiss_with_tick", 16'(bus_if.state), 16'd1);

    retrigger();
`ifdef ALARM_SNOOZE_EN
    press(1'b0, 1'b1);
    check("snooze_enter", 16'(bus_if.state), 16'd3);
    check("snooze_left_2", 16'(bus_if.snooze_left), 16'd2);
    check("snooze_silent", 16'(bus_if.ring), 16'd0);
    ticks(9);
    check("snooze_9_ticks", 16'(bus_if.state), 16'd3);
    ticks(1);
    check("snooze_expired", 16'(bus_if.state), 16'd2);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("dismiss_in_snooze", 16'(bus_if.state), 16'd1);
    check("dismiss_in_snooze_left", 16'(bus_if.snooze_left), 16'd1);
    retrigger();
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1);
      ticks(10);
    end
    check("after_3_snoozes", 16'(bus_if.state), 16'd2);
    check("after_3_snoozes_left", 16'(bus_if.snooze_left), 16'd0);
    press(1'b0, 1'b1);
    check("fourth_snooze_ignored", 16'(bus_if.state), 16'd2);
`else
    press(1'b0, 1'b1);
    check("push_u_ignored_state", 16'(bus_if.state), 16'd2);
    check("push_u_ignored_left", 16'(bus_if.snooze_left), 16'd0);
`endif
    press(1'b1, 1'b0);
    check("final_dismiss", 16'(bus_if.state), 16'd1);

    // Overrides: setting and enable switch
    retrigger();
    bus_if.setting = 1'b1; cyc();
    check("setting_idle", 16'(bus_if.state), 16'd0);
    check("setting_ring_off", 16'(bus_if.ring), 16'd0);
    bus_if.setting = 1'b0; cycles(6);
    check("rearm_on_match_no_fire", 16'(bus_if.state), 16'd1);
    retrigger();
    bus_if.alarm_en = 1'b0; cyc();
    check("disable_idle", 16'(bus_if.state), 16'd0);
    check("disable_ring_off", 16'(bus_if.ring), 16'd0);
    bus_if.alarm_en = 1'b1; cycles(2);

    // Asynchronous reset mid-ring
    retrigger();
    check("ring_before_reset", 16'(bus_if.ring), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_ring", 16'(bus_if.ring), 16'd0);
    check("async_reset_state", 16'(bus_if.state), 16'd0);
    #10 reset_n = 1'b1;
    cycles(3);
    check("rearm_after_reset", 16'(bus_if.state), 16'd1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
